// File: rtl/lookup_rule_cfg.sv
// Configuration-side writer for one stage's type-lookup rule table.
// Decodes a 32-bit command stream into one-hot rule writes and returns one status word per command.
module lookup_rule_cfg #(
    parameter int unsigned RULE_NUM = 8,
    parameter int unsigned RULE_W   = 96,
    parameter logic [7:0]  STAGE_ID = 8'd0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cfg_valid,
    input  logic [31:0]         i_cfg_data,
    output logic                o_cfg_ready,
    output logic [RULE_NUM-1:0] o_rule_wren,
    output logic [RULE_W-1:0]   o_type_rule,
    output logic                o_rsp_valid,
    output logic [31:0]         o_rsp_data,
    input  logic                i_rsp_ready,
    output logic                o_busy,
    output logic [15:0]         o_cmd_cnt,
    output logic [15:0]         o_err_cnt
);

    localparam int unsigned NWORDS    = (RULE_W + 31) / 32;
    localparam logic [7:0]  LAST_WORD = 8'(NWORDS - 1);

    localparam logic [3:0] OP_WRITE     = 4'd1;
    localparam logic [3:0] OP_CLEAR_ONE = 4'd2;
    localparam logic [3:0] OP_CLEAR_ALL = 4'd3;

    localparam logic [2:0] HDR     = 3'd0;
    localparam logic [2:0] PAYLOAD = 3'd1;
    localparam logic [2:0] SKIP    = 3'd2;
    localparam logic [2:0] COMMIT  = 3'd3;
    localparam logic [2:0] RSP     = 3'd4;

    logic [2:0]             state_q;
    logic [7:0]             word_cnt;
    logic [15:0]            index_q;
    logic [3:0]             status_q;
    logic [15:0]            rsp_idx_q;
    logic [NWORDS*32-1:0]   asm_q;
    logic [NWORDS*32-1:0]   asm_next;

    logic                   hs;
    logic                   stage_hit;
    logic [3:0]             hdr_op;
    logic [15:0]            hdr_idx;
    logic                   enter_commit;
    logic [3:0]             commit_op;
    logic [15:0]            commit_idx;
    logic                   in_range;
    logic [RULE_NUM-1:0]    onehot;
    logic                   unused_bits;

    assign hdr_op      = i_cfg_data[31:28];
    assign hdr_idx     = i_cfg_data[15:0];
    assign stage_hit   = (i_cfg_data[27:20] == STAGE_ID);
    assign unused_bits = ^i_cfg_data[19:16];

    assign o_cfg_ready = (state_q == HDR) || (state_q == PAYLOAD) || (state_q == SKIP);
    assign o_busy      = (state_q != HDR);
    assign hs          = i_cfg_valid && o_cfg_ready;

    // The write pulse and rule data are decided on the edge that enters COMMIT,
    // so both are registered and valid for the whole COMMIT cycle.
    always_comb begin
        asm_next = asm_q;
        asm_next[int'(word_cnt)*32 +: 32] = i_cfg_data;
        enter_commit = 1'b0;
        commit_op    = hdr_op;
        commit_idx   = hdr_idx;
        case (state_q)
            HDR: begin
                if (hs && stage_hit && (hdr_op == OP_CLEAR_ONE || hdr_op == OP_CLEAR_ALL))
                    enter_commit = 1'b1;
            end
            PAYLOAD: begin
                if (hs && word_cnt == LAST_WORD) begin
                    enter_commit = 1'b1;
                    commit_op    = OP_WRITE;
                    commit_idx   = index_q;
                end
            end
            default: ;
        endcase
        in_range = (32'(commit_idx) < RULE_NUM);
        onehot   = RULE_NUM'(1) << commit_idx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= HDR;
            word_cnt    <= '0;
            index_q     <= '0;
            status_q    <= '0;
            rsp_idx_q   <= '0;
            asm_q       <= '0;
            o_rule_wren <= '0;
            o_type_rule <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_cmd_cnt   <= '0;
            o_err_cnt   <= '0;
        end else begin
            o_rule_wren <= '0;
            if (enter_commit) begin
                if (commit_op == OP_CLEAR_ALL) begin
                    o_rule_wren <= '1;
                    o_type_rule <= '0;
                    status_q    <= 4'd0;
                    rsp_idx_q   <= 16'hFFFF;
                end else if (in_range) begin
                    o_rule_wren <= onehot;
                    o_type_rule <= (commit_op == OP_WRITE) ? asm_next[RULE_W-1:0] : '0;
                    status_q    <= 4'd0;
                    rsp_idx_q   <= commit_idx;
                end else begin
                    status_q    <= 4'd1;
                    rsp_idx_q   <= commit_idx;
                end
            end

            case (state_q)
                HDR: begin
                    if (hs) begin
                        index_q  <= hdr_idx;
                        word_cnt <= '0;
                        if (!stage_hit) begin
                            if (hdr_op == OP_WRITE)
                                state_q <= SKIP;
                        end else begin
                            case (hdr_op)
                                OP_WRITE:                  state_q <= PAYLOAD;
                                OP_CLEAR_ONE, OP_CLEAR_ALL: state_q <= COMMIT;
                                default: begin
                                    o_rsp_data  <= {4'd2, 12'd0, hdr_idx};
                                    o_rsp_valid <= 1'b1;
                                    state_q     <= RSP;
                                end
                            endcase
                        end
                    end
                end
                PAYLOAD: begin
                    if (hs) begin
                        asm_q <= asm_next;
                        if (word_cnt == LAST_WORD)
                            state_q <= COMMIT;
                        else
                            word_cnt <= word_cnt + 8'd1;
                    end
                end
                SKIP: begin
                    if (hs) begin
                        if (word_cnt == LAST_WORD)
                            state_q <= HDR;
                        else
                            word_cnt <= word_cnt + 8'd1;
                    end
                end
                COMMIT: begin
                    o_rsp_data  <= {status_q, 12'd0, rsp_idx_q};
                    o_rsp_valid <= 1'b1;
                    state_q     <= RSP;
                end
                RSP: begin
                    // Counters track responses actually delivered to the host.
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state_q     <= HDR;
                        if (o_rsp_data[31:28] == 4'd0) begin
                            if (o_cmd_cnt != 16'hFFFF)
                                o_cmd_cnt <= o_cmd_cnt + 16'd1;
                        end else begin
                            if (o_err_cnt != 16'hFFFF)
                                o_err_cnt <= o_err_cnt + 16'd1;
                        end
                    end
                end
                default: state_q <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_rule_cfg.sv
// Directed testbench for lookup_rule_cfg: one task per scenario with hand-computed expectations.
module tb_lookup_rule_cfg;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic [31:0] i_cfg_data = 32'd0;
    logic        i_rsp_ready = 1'b0;
    logic        o_cfg_ready;
    logic [7:0]  o_rule_wren;
    logic [95:0] o_type_rule;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_busy;
    logic [15:0] o_cmd_cnt;
    logic [15:0] o_err_cnt;

    int errors = 0;
    int checks = 0;
    int wren_cycles = 0;

    lookup_rule_cfg #(.RULE_NUM(8), .RULE_W(96), .STAGE_ID(8'd0)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_cfg_valid(i_cfg_valid),
        .i_cfg_data(i_cfg_data),
        .o_cfg_ready(o_cfg_ready),
        .o_rule_wren(o_rule_wren),
        .o_type_rule(o_type_rule),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_data(o_rsp_data),
        .i_rsp_ready(i_rsp_ready),
        .o_busy(o_busy),
        .o_cmd_cnt(o_cmd_cnt),
        .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_rule_wren != 8'h00)
            wren_cycles++;
    end

    task automatic send_word(input logic [31:0] d);
        int n;
        @(negedge i_clk);
        i_cfg_valid = 1'b1;
        i_cfg_data  = d;
        n = 0;
        while (!o_cfg_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_cfg_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_word timeout: cfg_ready=%b required 1", o_cfg_ready);
        end
        @(posedge i_clk);
        #1 i_cfg_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_rsp_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_rsp_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_rsp timeout: rsp_valid=%b required 1", o_rsp_valid);
        end
    endtask

    task automatic ack_rsp();
        @(negedge i_clk);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1 i_rsp_ready = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (o_rule_wren !== 8'h00 || o_type_rule !== 96'd0) begin
            errors++;
            $display("[TB] FAIL reset_rule: wren=%h rule=%h required 00 / 0", o_rule_wren, o_type_rule);
        end
        checks++;
        if (o_rsp_valid !== 1'b0 || o_rsp_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: valid=%b data=%h required 0 / 0", o_rsp_valid, o_rsp_data);
        end
        checks++;
        if (o_cmd_cnt !== 16'd0 || o_err_cnt !== 16'd0 || o_busy !== 1'b0 || o_cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: cmd=%h err=%h busy=%b ready=%b required 0 0 0 1",
                     o_cmd_cnt, o_err_cnt, o_busy, o_cfg_ready);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_write();
        int base;
        base = wren_cycles;
        send_word(32'h1000_0003);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        @(negedge i_clk);
        checks++;
        if (o_rule_wren !== 8'h08 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_wren: wren=%h rsp_valid=%b required 08 / 0", o_rule_wren, o_rsp_valid);
        end
        checks++;
        if (o_type_rule !== 96'h3333_3333_2222_2222_1111_1111) begin
            errors++;
            $display("[TB] FAIL write_rule: got %h required 333333332222222211111111", o_type_rule);
        end
        @(negedge i_clk);
        checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0000_0003 || o_rule_wren !== 8'h00) begin
            errors++;
            $display("[TB] FAIL write_rsp: valid=%b data=%h wren=%h required 1 / 00000003 / 00",
                     o_rsp_valid, o_rsp_data, o_rule_wren);
        end
        checks++;
        if (o_type_rule !== 96'h3333_3333_2222_2222_1111_1111) begin
            errors++;
            $display("[TB] FAIL write_rule_hold: got %h required 333333332222222211111111", o_type_rule);
        end
        ack_rsp();
        checks++;
        if (o_cmd_cnt !== 16'd1 || o_busy !== 1'b0 || (wren_cycles - base) != 1) begin
            errors++;
            $display("[TB] FAIL write_cnt: cmd=%0d busy=%b pulses=%0d required 1 / 0 / 1",
                     o_cmd_cnt, o_busy, wren_cycles - base);
        end
    endtask

    task automatic test_bad_index();
        int base;
        base = wren_cycles;
        send_word(32'h1000_0009);
        send_word(32'h4444_4444);
        send_word(32'h5555_5555);
        send_word(32'h6666_6666);
        wait_rsp();
        checks++;
        if (o_rsp_data !== 32'h1000_0009) begin
            errors++;
            $display("[TB] FAIL bad_index_rsp: got %h required 10000009", o_rsp_data);
        end
        ack_rsp();
        checks++;
        if (o_err_cnt !== 16'd1 || o_cmd_cnt !== 16'd1 || (wren_cycles - base) != 0) begin
            errors++;
            $display("[TB] FAIL bad_index_cnt: err=%0d cmd=%0d pulses=%0d required 1 / 1 / 0",
                     o_err_cnt, o_cmd_cnt, wren_cycles - base);
        end
    endtask

    task automatic test_clear_all();
        send_word(32'h3000_0000);
        @(negedge i_clk);
        checks++;
        if (o_rule_wren !== 8'hFF || o_type_rule !== 96'd0) begin
            errors++;
            $display("[TB] FAIL clear_all_wren: wren=%h rule=%h required FF / 0", o_rule_wren, o_type_rule);
        end
        @(negedge i_clk);
        checks++;
        if (o_rule_wren !== 8'h00 || o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0000_FFFF) begin
            errors++;
            $display("[TB] FAIL clear_all_rsp: wren=%h valid=%b data=%h required 00 / 1 / 0000FFFF",
                     o_rule_wren, o_rsp_valid, o_rsp_data);
        end
        ack_rsp();
        checks++;
        if (o_cmd_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL clear_all_cnt: got %0d required 2", o_cmd_cnt);
        end
    endtask

    task automatic test_skip();
        int base;
        base = wren_cycles;
        send_word(32'h1050_0003);
        send_word(32'h3000_0000);
        send_word(32'h2000_0001);
        send_word(32'h1000_0002);
        send_word(32'h2050_0001);
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0 || (wren_cycles - base) != 0) begin
            errors++;
            $display("[TB] FAIL skip_idle: busy=%b rsp_valid=%b pulses=%0d required 0 / 0 / 0",
                     o_busy, o_rsp_valid, wren_cycles - base);
        end
        send_word(32'h2000_0002);
        @(negedge i_clk);
        checks++;
        if (o_rule_wren !== 8'h04 || o_type_rule !== 96'd0) begin
            errors++;
            $display("[TB] FAIL skip_clear_one: wren=%h rule=%h required 04 / 0", o_rule_wren, o_type_rule);
        end
        wait_rsp();
        checks++;
        if (o_rsp_data !== 32'h0000_0002) begin
            errors++;
            $display("[TB] FAIL skip_rsp: got %h required 00000002", o_rsp_data);
        end
        ack_rsp();
        checks++;
        if (o_cmd_cnt !== 16'd3 || (wren_cycles - base) != 1) begin
            errors++;
            $display("[TB] FAIL skip_cnt: cmd=%0d pulses=%0d required 3 / 1", o_cmd_cnt, wren_cycles - base);
        end
    endtask

    task automatic test_illegal();
        int base;
        base = wren_cycles;
        send_word(32'h7000_0005);
        wait_rsp();
        checks++;
        if (o_rsp_data !== 32'h2000_0005) begin
            errors++;
            $display("[TB] FAIL illegal_rsp: got %h required 20000005", o_rsp_data);
        end
        ack_rsp();
        checks++;
        if (o_err_cnt !== 16'd2 || o_cmd_cnt !== 16'd3 || (wren_cycles - base) != 0) begin
            errors++;
            $display("[TB] FAIL illegal_cnt: err=%0d cmd=%0d pulses=%0d required 2 / 3 / 0",
                     o_err_cnt, o_cmd_cnt, wren_cycles - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int stall_bad;
        send_word(32'h1000_0001);
        send_word(32'h0000_000A);
        send_word(32'h0000_000B);
        send_word(32'h0000_000C);
        wait_rsp();
        base = wren_cycles;
        i_cfg_valid = 1'b1;
        i_cfg_data  = 32'h2000_0004;
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_cfg_ready !== 1'b0 || o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0000_0001)
                stall_bad++;
        end
        checks++;
        if (stall_bad != 0 || (wren_cycles - base) != 0) begin
            errors++;
            $display("[TB] FAIL stall_hold: bad_cycles=%0d pulses=%0d required 0 / 0", stall_bad, wren_cycles - base);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1 i_rsp_ready = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_cfg_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: ready=%b rsp_valid=%b required 1 / 0", o_cfg_ready, o_rsp_valid);
        end
        @(posedge i_clk);
        #1 i_cfg_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_rule_wren !== 8'h10) begin
            errors++;
            $display("[TB] FAIL stall_next_hdr: wren=%h required 10", o_rule_wren);
        end
        wait_rsp();
        checks++;
        if (o_rsp_data !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL stall_next_rsp: got %h required 00000004", o_rsp_data);
        end
        ack_rsp();
        checks++;
        if (o_cmd_cnt !== 16'd5 || (wren_cycles - base) != 1) begin
            errors++;
            $display("[TB] FAIL stall_cnt: cmd=%0d pulses=%0d required 5 / 1", o_cmd_cnt, wren_cycles - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = wren_cycles;
        send_word(32'h1000_0006);
        send_word(32'h7777_7777);
        send_word(32'h8888_8888);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_cmd_cnt !== 16'd0 || o_err_cnt !== 16'd0 || o_type_rule !== 96'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_state: busy=%b cmd=%0d err=%0d rule=%h required 0 / 0 / 0 / 0",
                     o_busy, o_cmd_cnt, o_err_cnt, o_type_rule);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ((wren_cycles - base) != 0 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_quiet: pulses=%0d rsp_valid=%b required 0 / 0", wren_cycles - base, o_rsp_valid);
        end
        send_word(32'h1000_0000);
        send_word(32'hAAAA_0000);
        send_word(32'hBBBB_0001);
        send_word(32'hCCCC_0002);
        @(negedge i_clk);
        checks++;
        if (o_rule_wren !== 8'h01 || o_type_rule !== 96'hCCCC_0002_BBBB_0001_AAAA_0000) begin
            errors++;
            $display("[TB] FAIL reset_mid_write: wren=%h rule=%h required 01 / CCCC0002BBBB0001AAAA0000",
                     o_rule_wren, o_type_rule);
        end
        wait_rsp();
        checks++;
        if (o_rsp_data !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL reset_mid_rsp: got %h required 00000000", o_rsp_data);
        end
        ack_rsp();
        checks++;
        if (o_cmd_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL reset_mid_cnt: got %0d required 1", o_cmd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_index();
        test_clear_all();
        test_skip();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
